// File: rtl/branch_flag_unit_if.sv
// rtl/branch_flag_unit_if.sv - decode/ALU to branch_flag_unit signal bundle
interface branch_flag_unit_if #(
    parameter int PC_W     = 10,
    parameter int OFFSET_W = 8
);
    logic                Start;
    logic                FlagWe;
    logic                ZeroIn;
    logic                LTIn;
    logic                BrValid;
    logic [1:0]          BrCond;
    logic [OFFSET_W-1:0] BrOffset;
    logic                Halt;
    logic [PC_W-1:0]     PC;
    logic [PC_W-1:0]     ExPC;
    logic                ExValid;
    logic                Flush;
    logic                ZeroFlag;
    logic                LTFlag;
    logic                Done;

    // Decode/ALU side: drives execute-stage controls, observes fetch state
    modport master (
        output Start, FlagWe, ZeroIn, LTIn, BrValid, BrCond, BrOffset, Halt,
        input  PC, ExPC, ExValid, Flush, ZeroFlag, LTFlag, Done
    );

    // Flag/branch unit side
    modport slave (
        input  Start, FlagWe, ZeroIn, LTIn, BrValid, BrCond, BrOffset, Halt,
        output PC, ExPC, ExValid, Flush, ZeroFlag, LTFlag, Done
    );
endinterface

// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - flag register, branch resolution and fetch PC owner
module branch_flag_unit #(
    parameter int PC_W     = 10,
    parameter int OFFSET_W = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    branch_flag_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_RUN,
        S_REDIRECT,
        S_HALTED
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_ZERO = '0;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ex_pc_q, ex_pc_d;
    logic            ex_valid_q, ex_valid_d;
    logic            flush_q, flush_d;
    logic            zero_q, zero_d;
    logic            lt_q, lt_d;

    logic            active;
    logic            eff_zero;
    logic            eff_lt;
    logic            taken;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;

    // Branch resolution: flags written this cycle are forwarded into the compare
    always_comb begin
        active   = (state_q == S_RUN) && ex_valid_q;
        eff_zero = bus.FlagWe ? bus.ZeroIn : zero_q;
        eff_lt   = bus.FlagWe ? bus.LTIn   : lt_q;
        unique case (bus.BrCond)
            2'b00:   taken = eff_zero;
            2'b01:   taken = !eff_zero;
            2'b10:   taken = eff_lt;
            default: taken = 1'b1;
        endcase
        off_ext = {{(PC_W-OFFSET_W){bus.BrOffset[OFFSET_W-1]}}, bus.BrOffset};
        target  = ex_pc_q + off_ext;
    end

    // Next-state and datapath updates; Halt outranks a taken branch
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ex_pc_d    = ex_pc_q;
        ex_valid_d = 1'b0;
        flush_d    = 1'b0;
        zero_d     = zero_q;
        lt_d       = lt_q;

        unique case (state_q)
            S_IDLE: begin
                pc_d = PC_ZERO;
                if (bus.Start) begin
                    state_d = S_FETCH0;
                end
            end
            S_FETCH0: begin
                ex_pc_d    = PC_ZERO;
                pc_d       = PC_ONE;
                ex_valid_d = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (active && bus.FlagWe) begin
                    zero_d = bus.ZeroIn;
                    lt_d   = bus.LTIn;
                end
                if (active && bus.Halt) begin
                    state_d = S_HALTED;
                end else if (active && bus.BrValid && taken) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                    state_d = S_REDIRECT;
                end else begin
                    ex_pc_d    = pc_q;
                    pc_d       = pc_q + PC_ONE;
                    ex_valid_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                // The squashed slot carries no instruction, so its controls are dropped
                ex_pc_d    = pc_q;
                pc_d       = pc_q + PC_ONE;
                ex_valid_d = 1'b1;
                state_d    = S_RUN;
            end
            S_HALTED: begin
                if (bus.Start) begin
                    zero_d  = 1'b0;
                    lt_d    = 1'b0;
                    pc_d    = PC_ZERO;
                    state_d = S_FETCH0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and architectural registers; reset wipes any pending redirect
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ex_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            zero_q     <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ex_pc_q    <= ex_pc_d;
            ex_valid_q <= ex_valid_d;
            flush_q    <= flush_d;
            zero_q     <= zero_d;
            lt_q       <= lt_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.ExPC     = ex_pc_q;
    assign bus.ExValid  = ex_valid_q;
    assign bus.Flush    = flush_q;
    assign bus.ZeroFlag = zero_q;
    assign bus.LTFlag   = lt_q;
    assign bus.Done     = (state_q == S_HALTED);
endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - directed self-checking bench for branch_flag_unit
module tb_branch_flag_unit;
    logic Clk;
    logic Reset_n;
    int   tests_run;
    int   tests_failed;

    branch_flag_unit_if #(.PC_W(10), .OFFSET_W(8)) bus ();

    branch_flag_unit #(.PC_W(10), .OFFSET_W(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start    = 1'b0;
        bus.FlagWe   = 1'b0;
        bus.ZeroIn   = 1'b0;
        bus.LTIn     = 1'b0;
        bus.BrValid  = 1'b0;
        bus.BrCond   = 2'b00;
        bus.BrOffset = 8'd0;
        bus.Halt     = 1'b0;
    endtask

    task automatic branch(input logic [1:0] cond, input logic [7:0] off);
        bus.BrValid  = 1'b1;
        bus.BrCond   = cond;
        bus.BrOffset = off;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        Reset_n = 1'b0;
        #12;
        check("rst_pc", 32'(bus.PC), 0);
        check("rst_exvalid", 32'(bus.ExValid), 0);
        check("rst_done", 32'(bus.Done), 0);
        Reset_n = 1'b1;
        step();
        check("idle_pc", 32'(bus.PC), 0);

        // Sequential start-up
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check("fetch0_pc", 32'(bus.PC), 0);
        check("fetch0_exvalid", 32'(bus.ExValid), 0);
        step();
        check("run_pc1", 32'(bus.PC), 1);
        check("run_expc0", 32'(bus.ExPC), 0);
        check("run_exvalid", 32'(bus.ExValid), 1);
        step();
        step();
        step();
        check("run_pc4", 32'(bus.PC), 4);
        check("run_expc3", 32'(bus.ExPC), 3);
        step();
        step();
        step();
        check("at_expc6", 32'(bus.ExPC), 6);

        // Forwarded EQ taken, branch offered during REDIRECT must be dropped
        bus.FlagWe = 1'b1;
        bus.ZeroIn = 1'b1;
        branch(2'b00, 8'hFC);
        step();
        check("fwd_flush", 32'(bus.Flush), 1);
        check("fwd_pc", 32'(bus.PC), 2);
        check("fwd_exvalid", 32'(bus.ExValid), 0);
        check("fwd_zflag", 32'(bus.ZeroFlag), 1);
        idle_inputs();
        branch(2'b11, 8'd20);
        step();
        check("redir_expc", 32'(bus.ExPC), 2);
        check("redir_pc", 32'(bus.PC), 3);
        check("redir_flush_clr", 32'(bus.Flush), 0);
        idle_inputs();

        // Flags Z=0 LT=1; NE taken, EQ not taken
        bus.FlagWe = 1'b1;
        bus.LTIn   = 1'b1;
        step();
        idle_inputs();
        check("flag_z0", 32'(bus.ZeroFlag), 0);
        check("flag_lt1", 32'(bus.LTFlag), 1);
        for (int i = 0; i < 6; i++) step();
        check("at_expc9", 32'(bus.ExPC), 9);
        branch(2'b00, 8'd3);
        step();
        check("eq_nt_pc", 32'(bus.PC), 11);
        check("eq_nt_expc", 32'(bus.ExPC), 10);
        check("eq_nt_flush", 32'(bus.Flush), 0);
        branch(2'b01, 8'd3);
        step();
        check("ne_t_pc", 32'(bus.PC), 13);
        check("ne_t_flush", 32'(bus.Flush), 1);
        idle_inputs();
        step();
        check("ne_t_expc", 32'(bus.ExPC), 13);

        // Forward wrap of the branch target
        for (int i = 0; i < 1100 && bus.ExPC != 10'd1020; i++) step();
        check("reach_1020", 32'(bus.ExPC), 1020);
        branch(2'b11, 8'd8);
        step();
        idle_inputs();
        check("wrap_tgt_pc", 32'(bus.PC), 4);
        check("wrap_tgt_flush", 32'(bus.Flush), 1);
        step();
        check("wrap_tgt_expc", 32'(bus.ExPC), 4);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check("start_in_run_pc", 32'(bus.PC), 6);

        // LT taken backward across zero, then sequential wrap 1023 -> 0
        branch(2'b10, 8'hF8);
        step();
        idle_inputs();
        check("lt_t_pc", 32'(bus.PC), 1021);
        step();
        step();
        step();
        check("seq_wrap_expc", 32'(bus.ExPC), 1023);
        check("seq_wrap_pc", 32'(bus.PC), 0);
        step();

        // Halt outranks a taken branch; flags still written
        bus.Halt   = 1'b1;
        bus.FlagWe = 1'b1;
        bus.ZeroIn = 1'b1;
        bus.LTIn   = 1'b1;
        branch(2'b11, 8'd5);
        step();
        idle_inputs();
        check("halt_done", 32'(bus.Done), 1);
        check("halt_flush", 32'(bus.Flush), 0);
        check("halt_pc", 32'(bus.PC), 1);
        check("halt_exvalid", 32'(bus.ExValid), 0);
        check("halt_zflag", 32'(bus.ZeroFlag), 1);
        check("halt_ltflag", 32'(bus.LTFlag), 1);
        step();
        check("halt_frozen_pc", 32'(bus.PC), 1);
        check("halt_frozen_expc", 32'(bus.ExPC), 0);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check("restart_pc", 32'(bus.PC), 0);
        check("restart_zflag", 32'(bus.ZeroFlag), 0);
        check("restart_ltflag", 32'(bus.LTFlag), 0);
        check("restart_done", 32'(bus.Done), 0);
        step();
        check("resume_pc", 32'(bus.PC), 1);
        check("resume_exvalid", 32'(bus.ExValid), 1);

        // Asynchronous reset mid-RUN at PC=5
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_pc", 32'(bus.PC), 5);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(bus.PC), 0);
        check("async_rst_expc", 32'(bus.ExPC), 0);
        check("async_rst_exvalid", 32'(bus.ExValid), 0);
        step();
        #2;
        Reset_n = 1'b1;
        step();
        check("post_rst_idle_pc", 32'(bus.PC), 0);
        check("post_rst_idle_exvalid", 32'(bus.ExValid), 0);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        check("post_rst_pc", 32'(bus.PC), 1);
        check("post_rst_expc", 32'(bus.ExPC), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
